// File: rtl/dma_periph_requester.sv
// Peripheral-side 8237A DREQ/DACK endpoint: a device-fed FIFO drained by DMA I/O reads.
// Optional DMA_PERIPH_EOP_GEN_EN adds a transfer-length counter that generates EOP locally.
module dma_periph_requester #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int THRESH     = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dreq_pol,
    input  logic              dack_pol,
    input  logic [1:0]        mode,
    input  logic              dev_valid,
    input  logic [DATA_W-1:0] dev_data,
    output logic              dev_ready,
    output logic              DREQ,
    input  logic              DACK,
    input  logic              IOR_n,
    input  logic              EOP_n,
    output logic [DATA_W-1:0] DB,
    output logic              db_oe,
    output logic              tc_flag,
    input  logic              tc_clr,
    output logic              err_flag
`ifdef DMA_PERIPH_EOP_GEN_EN
    ,
    input  logic [15:0]       xfer_len,
    input  logic              len_load,
    output logic              eop_out_n
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] THRESH_C = CW'(THRESH);

    typedef enum logic [1:0] {IDLE, REQ, XFER, HOLDOFF} state_e;

    state_e            state_q, state_d;
    logic              req_q, req_d;
    logic              ior_q;
    logic              tc_q, tc_d;
    logic              err_q, err_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];

    logic ack, pop_ev, do_pop, do_push, blk, start, eop, eop_act, err_set;

    assign ack     = DACK ^ ~dack_pol;
    assign pop_ev  = ack & IOR_n & ~ior_q;
    assign do_pop  = pop_ev && (state_q == XFER) && (count_q != '0);
    // A full FIFO still accepts a push when the same cycle pops.
    assign do_push = dev_valid && ((count_q != DEPTH_C) || do_pop);
    assign blk     = (mode == 2'b10);
    assign start   = blk ? (count_q >= THRESH_C) : (count_q != '0);
    assign eop_act = eop && (state_q != IDLE);
    assign err_set = (ack && (state_q == IDLE || state_q == HOLDOFF))
                   || (pop_ev && count_q == '0);

    assign DREQ      = req_q ^ dreq_pol;
    assign dev_ready = (count_q != DEPTH_C);
    assign db_oe     = ack && !IOR_n && (state_q == XFER);
    assign DB        = db_oe ? mem_q[rd_ptr_q] : '0;
    assign tc_flag   = tc_q;
    assign err_flag  = err_q;

`ifdef DMA_PERIPH_EOP_GEN_EN
    logic [15:0] len_q, len_d;
    logic        eop_gen_q, eop_gen_d;

    always_comb begin
        len_d     = len_q;
        eop_gen_d = 1'b0;
        if (len_load) begin
            len_d = xfer_len;
        end else if (do_pop && len_q != 16'd0) begin
            len_d     = len_q - 16'd1;
            eop_gen_d = (len_q == 16'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            len_q     <= '0;
            eop_gen_q <= 1'b0;
        end else begin
            len_q     <= len_d;
            eop_gen_q <= eop_gen_d;
        end
    end

    assign eop_out_n = ~eop_gen_q;
    assign eop       = ~EOP_n | eop_gen_q;
`else
    assign eop = ~EOP_n;
`endif

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = dev_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop)
            rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)
            count_d = count_q + CW'(1);
        else if (do_pop && !do_push)
            count_d = count_q - CW'(1);
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                end
            end
            REQ: begin
                if (ack)
                    state_d = XFER;
            end
            XFER: begin
                if (do_pop) begin
                    if (mode == 2'b00 || blk) begin
                        if (count_d == '0) begin
                            req_d   = 1'b0;
                            state_d = IDLE;
                        end
                    end else begin
                        req_d   = 1'b0;
                        state_d = HOLDOFF;
                    end
                end else if (!ack) begin
                    state_d = req_q ? REQ : IDLE;
                end
            end
            HOLDOFF: begin
                // Pass through IDLE's start check so the release is exactly one cycle.
                if (start) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (eop_act) begin
            req_d   = 1'b0;
            state_d = IDLE;
        end
    end

    always_comb begin
        tc_d  = tc_clr ? 1'b0 : (tc_q | eop_act);
        err_d = tc_clr ? 1'b0 : (err_q | err_set);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            ior_q    <= 1'b1;
            tc_q     <= 1'b0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            ior_q    <= IOR_n;
            tc_q     <= tc_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: tb/tb_dma_periph_requester.sv
// Directed bench for dma_periph_requester; covers the eop generator when DMA_PERIPH_EOP_GEN_EN is defined.
module tb_dma_periph_requester;

    logic       clk = 1'b0;
    logic       reset_n, dreq_pol, dack_pol, dev_valid, dev_ready, DREQ, DACK, IOR_n, EOP_n;
    logic       db_oe, tc_flag, tc_clr, err_flag;
    logic [1:0] mode;
    logic [7:0] dev_data, DB;
    logic       dack_on;
`ifdef DMA_PERIPH_EOP_GEN_EN
    logic [15:0] xfer_len;
    logic        len_load, eop_out_n;
`endif
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dma_periph_requester #(.DATA_W(8), .FIFO_DEPTH(8), .THRESH(4)) dut (
        .clk(clk), .reset_n(reset_n), .dreq_pol(dreq_pol), .dack_pol(dack_pol), .mode(mode),
        .dev_valid(dev_valid), .dev_data(dev_data), .dev_ready(dev_ready), .DREQ(DREQ),
        .DACK(DACK), .IOR_n(IOR_n), .EOP_n(EOP_n), .DB(DB), .db_oe(db_oe),
        .tc_flag(tc_flag), .tc_clr(tc_clr), .err_flag(err_flag)
`ifdef DMA_PERIPH_EOP_GEN_EN
        , .xfer_len(xfer_len), .len_load(len_load), .eop_out_n(eop_out_n)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        DACK    = ~dack_on;
        IOR_n   = 1'b1;
        tick;
        tick;
        reset_n = 1'b1;
    endtask

    task automatic push(input logic [7:0] b);
        dev_valid = 1'b1;
        dev_data  = b;
        tick;
        dev_valid = 1'b0;
    endtask

    // One DACK + IOR_n pulse; pop lands on the third edge, DACK released afterwards.
    task automatic rd(input string tag, input logic [7:0] exp);
        DACK  = dack_on;
        IOR_n = 1'b1;
        tick;
        IOR_n = 1'b0;
        #1;
        chk({tag, "_oe"}, db_oe, 1);
        chk({tag, "_db"}, DB, exp);
        tick;
        IOR_n = 1'b1;
        tick;
        DACK = ~dack_on;
    endtask

    initial begin
        reset_n = 1'b0; dreq_pol = 1'b0; dack_pol = 1'b1; dack_on = 1'b1; mode = 2'b01;
        dev_valid = 1'b0; dev_data = '0; DACK = 1'b0; IOR_n = 1'b1; EOP_n = 1'b1; tc_clr = 1'b0;
`ifdef DMA_PERIPH_EOP_GEN_EN
        xfer_len = '0; len_load = 1'b0;
`endif
        do_reset;
        chk("rst_dreq", DREQ, 0);
        chk("rst_ready", dev_ready, 1);
        chk("rst_oe", db_oe, 0);
        chk("rst_db", DB, 0);
        chk("rst_tc", tc_flag, 0);
        chk("rst_err", err_flag, 0);

        // single mode
        push(8'hA5);
        chk("s_dreq_push0", DREQ, 0);
        push(8'h3C);
        chk("s_dreq_on", DREQ, 1);
        rd("s_rd0", 8'hA5);
        chk("s_holdoff", DREQ, 0);
        tick;
        chk("s_rereq", DREQ, 1);
        rd("s_rd1", 8'h3C);
        chk("s_rel", DREQ, 0);
        tick;
        tick;
        chk("s_idle", DREQ, 0);
        chk("s_cnt", dut.count_q, 0);
        chk("s_err", err_flag, 0);

        // block mode, threshold 4
        mode = 2'b10;
        do_reset;
        push(8'h11); push(8'h22); push(8'h33);
        tick;
        chk("b_below", DREQ, 0);
        push(8'h44);
        tick;
        chk("b_req", DREQ, 1);
        rd("b_rd0", 8'h11);
        rd("b_rd1", 8'h22);
        rd("b_rd2", 8'h33);
        chk("b_hold", DREQ, 1);
        rd("b_rd3", 8'h44);
        chk("b_drop", DREQ, 0);
        chk("b_cnt", dut.count_q, 0);

        // inverted polarity
        mode = 2'b01; dreq_pol = 1'b1; dack_pol = 1'b0; dack_on = 1'b0;
        do_reset;
        chk("i_rst_dreq", DREQ, 1);
        push(8'h5A);
        tick;
        chk("i_dreq", DREQ, 0);
        rd("i_rd", 8'h5A);
        chk("i_cnt", dut.count_q, 0);
        chk("i_err", err_flag, 0);
        dreq_pol = 1'b0; dack_pol = 1'b1; dack_on = 1'b1; DACK = 1'b0;

        // demand mode with EOP mid-burst
        mode = 2'b00;
        do_reset;
        for (int i = 1; i <= 5; i++) push(8'(i));
        rd("d_rd0", 8'h01);
        rd("d_rd1", 8'h02);
        EOP_n = 1'b0;
        tick;
        EOP_n = 1'b1;
        chk("d_eop_dreq", DREQ, 0);
        chk("d_eop_tc", tc_flag, 1);
        chk("d_eop_cnt", dut.count_q, 3);
        tc_clr = 1'b1;
        tick;
        tc_clr = 1'b0;
        chk("d_tcclr", tc_flag, 0);
        rd("d_rd2", 8'h03);
        chk("d_err", err_flag, 0);

        // full FIFO, dropped push, push+pop at full
        mode = 2'b01;
        do_reset;
        for (int i = 0; i < 8; i++) push(8'h80 + 8'(i));
        chk("f_ready", dev_ready, 0);
        chk("f_cnt8", dut.count_q, 8);
        push(8'hEE);
        chk("f_drop", dut.count_q, 8);
        DACK = 1'b1; IOR_n = 1'b1;
        tick;
        IOR_n = 1'b0;
        #1;
        chk("f_db", DB, 8'h80);
        tick;
        IOR_n = 1'b1; dev_valid = 1'b1; dev_data = 8'hF0;
        tick;
        dev_valid = 1'b0; DACK = 1'b0;
        chk("f_pp_cnt", dut.count_q, 8);
        chk("f_pp_ready", dev_ready, 0);
        tick;
        rd("f_next", 8'h81);

        // reset mid-transfer flushes and drops DREQ
        do_reset;
        chk("r_dreq", DREQ, 0);
        chk("r_cnt", dut.count_q, 0);

        // error flag: spurious DACK, clear priority, empty read
        DACK = 1'b1;
        tick;
        DACK = 1'b0;
        chk("e_spur", err_flag, 1);
        tc_clr = 1'b1;
        tick;
        chk("e_clr", err_flag, 0);
        DACK = 1'b1;
        tick;
        tc_clr = 1'b0; DACK = 1'b0;
        chk("e_clrprio", err_flag, 0);
        DACK = 1'b1; IOR_n = 1'b0;
        tick;
        IOR_n = 1'b1;
        tick;
        DACK = 1'b0;
        chk("e_empty", err_flag, 1);
        chk("e_cnt", dut.count_q, 0);

`ifdef DMA_PERIPH_EOP_GEN_EN
        mode = 2'b00;
        do_reset;
        xfer_len = 16'd2; len_load = 1'b1;
        tick;
        len_load = 1'b0;
        for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
        rd("g_rd0", 8'hC0);
        chk("g_eop_hi", eop_out_n, 1);
        rd("g_rd1", 8'hC1);
        chk("g_eop_lo", eop_out_n, 0);
        tick;
        chk("g_eop_rel", eop_out_n, 1);
        chk("g_dreq", DREQ, 0);
        chk("g_tc", tc_flag, 1);
        chk("g_cnt", dut.count_q, 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dma_periph_requester.md
Name: dma_periph_requester

Overview:
- Peripheral-side endpoint of the 8237A DREQ/DACK handshake. The device pushes bytes into a local FIFO.
- The block raises DREQ toward the DMA channel, then answers DACK + IOR_n read strobes by driving the FIFO head onto the data bus.
- It honours EOP_n termination.
- One instance sits beside each DMA-serviced I/O device and matches the controller's command-register polarity and mode settings.

Parameters:
- DATA_W, 8, data bus and FIFO width
- FIFO_DEPTH, 8, FIFO entries (power of two, >=2)
- THRESH, 4, fill level that starts a block-mode request (1..FIFO_DEPTH)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous active-low reset
- dreq_pol  in  1  0 = DREQ active high, 1 = DREQ active low (mirrors command bit 6)
- dack_pol  in  1  1 = DACK active high, 0 = DACK active low (mirrors command bit 7)
- mode  in  2  00 demand, 01 single, 10 block, 11 reserved (treated as single)
- dev_valid  in  1  device push strobe
- dev_data  in  DATA_W  device push data
- dev_ready  out  1  FIFO not full
- DREQ  out  1  request to DMA, polarity per dreq_pol
- DACK  in  1  acknowledge from DMA, polarity per dack_pol
- IOR_n  in  1  DMA I/O read strobe, active low
- EOP_n  in  1  end of process, active low
- DB  out  DATA_W  data toward DMA/memory
- db_oe  out  1  DB output enable
- tc_flag  out  1  sticky terminal-count/EOP seen
- tc_clr  in  1  clears tc_flag
- err_flag  out  1  sticky protocol error (spurious DACK or read of empty FIFO); cleared by tc_clr

Behaviour:
- Interface: one clock (clk); reset_n synchronous, active low.
- Decoded internal signals:
  - ack = DACK ^ !dack_pol
  - DREQ = req_q ^ dreq_pol, where req_q is an internal registered active-high request
  - pop = ack && IOR_n rising edge, detected against ior_q, the IOR_n value registered last cycle
- Reset values:
  - req_q=0, so DREQ sits at its inactive level (= dreq_pol)
  - FIFO empty; dev_ready=1; db_oe=0; DB=0; tc_flag=0; err_flag=0
  - state=IDLE; ior_q=1
- FSM states: IDLE, REQ, XFER, HOLDOFF.
- IDLE:
  - Goes to REQ and sets req_q next cycle when the start condition holds.
  - Start condition, demand/single: count>=1. Block: count>=THRESH.
- REQ:
  - req_q held.
  - ack high -> XFER.
- XFER:
  - db_oe=1 and DB=FIFO head while ack && !IOR_n; db_oe is combinational from the inputs.
  - On pop: FIFO read pointer advances.
  - Single: req_q cleared on the pop cycle -> HOLDOFF.
  - Demand: req_q stays set while count after pop >=1. Otherwise clear -> IDLE.
  - Block: req_q stays set until count after pop ==0 -> clear -> IDLE.
  - ack drops with no pop: return to REQ if req_q still set.
- HOLDOFF:
  - Lasts exactly one cycle with req_q=0, so the DMA sees the single-mode release.
  - Then -> IDLE.
- EOP_n low while state != IDLE:
  - Takes priority over everything.
  - Clears req_q next cycle, sets tc_flag, forces IDLE.
  - FIFO contents are kept.
  - A pop in the same cycle still completes.
- FIFO:
  - count is $clog2(FIFO_DEPTH)+1 bits wide; pointers wrap modulo FIFO_DEPTH.
  - dev_ready = count<FIFO_DEPTH.
  - A push when full is dropped.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - A push into an empty FIFO is visible for a request the next cycle.
- Errors (set err_flag, no state change):
  - Pop attempted with FIFO empty: no pointer change.
  - ack asserted while state is IDLE or HOLDOFF: ignored.
- Clear priority: tc_clr takes priority over a simultaneous set of either flag.
- Reset mid-transfer: everything returns to reset values on the next edge, the FIFO is flushed, and DREQ drops to inactive.
- Polarity inputs are assumed static while state != IDLE; changing them mid-transfer gives undefined results.

Optional Feature:
- Macro: DMA_PERIPH_EOP_GEN_EN
- When defined, the block adds:
  - inputs xfer_len[15:0] and len_load
  - output eop_out_n
- len_load loads a down-counter.
- Each pop decrements the counter. The pop that reaches 0 drives eop_out_n low for exactly one cycle (the cycle after that pop), then performs the EOP_n termination action internally.
- When undefined: none of these ports or the counter exist, and termination comes only from EOP_n.

Test Plan:
- Single mode, dreq_pol=0, dack_pol=1: push 0xA5, 0x3C -> DREQ=1 one cycle after the first push. DACK=1 plus an IOR_n pulse -> DB=0xA5 with db_oe=1 while IOR_n low. After the pop, DREQ=0 for exactly 1 cycle, then DREQ=1 again; the second pulse returns 0x3C, then DREQ stays 0.
- Block mode, THRESH=4: push 3 bytes -> DREQ stays inactive. The 4th push raises DREQ. 4 reads return the bytes in push order; DREQ drops on the 4th pop; count=0.
- Inverted polarity (dreq_pol=1, dack_pol=0): reset gives DREQ=1 (inactive). After a push, DREQ=0 (active). DACK=0 plus a read pops data.
- Demand mode: EOP_n low mid-burst with 5 bytes queued and 2 already read -> DREQ inactive next cycle, tc_flag=1, count=3. tc_clr -> tc_flag=0.
- Fill 8 bytes -> dev_ready=0 and a 9th push is dropped. Simultaneous push and pop at full -> count stays 8. A spurious DACK in IDLE and a read of an empty FIFO each set err_flag.
- With DMA_PERIPH_EOP_GEN_EN and xfer_len=2 in demand mode with 4 bytes queued: after the 2nd pop, eop_out_n is low for exactly 1 cycle, DREQ goes inactive and tc_flag=1.
